spi_slave_phy: RTL and testbench

//  SPI slave serial front end. Mode 0 (CPOL=0, CPHA=0), 16-bit frames, MSB first.

---
 rtl/spi_slave_phy.sv | 144 ++++++++++++++
 tb/tb_spi_slave_phy.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_phy.sv
// SPI mode-0 slave front end: oversampled SCK/CS_N/MOSI, 16-bit MSB-first frames in and out.
// rx strobe 1 clk after the synchronised final SCK rise; no backpressure, faults pulse spi_clk_error and drop the frame.
module spi_slave_phy #(
  parameter int FRAME_BITS = 16,
  parameter int MIN_PHASE  = 3,
  parameter int PH_CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_spi_cs_n,
  input  logic                  i_spi_sck,
  input  logic                  i_spi_mosi,
  output logic                  o_spi_miso,
  output logic                  o_spi_miso_oe,
  output logic                  o_rx_data_ready,
  output logic [FRAME_BITS-1:0] o_rx_data,
  input  logic                  i_tx_data_ready,
  input  logic [FRAME_BITS-1:0] i_tx_data,
  output logic                  o_spi_clk_error
);

  localparam int                BC_W     = $clog2(FRAME_BITS);
  localparam logic [BC_W-1:0]   LAST_BIT = BC_W'(FRAME_BITS - 1);
  localparam logic [PH_CNT_W-1:0] PH_MIN = PH_CNT_W'(MIN_PHASE - 1);

  logic [2:0]            r_sck_s;
  logic [2:0]            r_cs_s;
  logic [1:0]            r_mosi_s;
  logic [1:0]            r_sync_ok;
  logic                  r_abort;
  logic                  r_armed;
  logic [BC_W-1:0]       r_bit_cnt;
  logic [PH_CNT_W-1:0]   r_ph_cnt;
  logic [FRAME_BITS-1:0] r_rx_shift;
  logic [FRAME_BITS-1:0] r_tx_hold;
  logic [FRAME_BITS-1:0] r_tx_shift;

  logic w_sck_rise, w_sck_fall, w_sck_edge;
  logic w_cs_n, w_cs_fall, w_mosi, w_active;
  logic w_f1, w_f2, w_f3, w_fault;
  logic w_rx_take, w_frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_s   <= 3'b000;
      r_cs_s    <= 3'b111;
      r_mosi_s  <= 2'b00;
      r_sync_ok <= 2'b00;
    end else begin
      r_sck_s   <= {r_sck_s[1:0], i_spi_sck};
      r_cs_s    <= {r_cs_s[1:0], i_spi_cs_n};
      r_mosi_s  <= {r_mosi_s[0], i_spi_mosi};
      r_sync_ok <= {r_sync_ok[0], 1'b1};
    end
  end

  assign w_sck_rise = r_sck_s[1] & ~r_sck_s[2];
  assign w_sck_fall = ~r_sck_s[1] & r_sck_s[2];
  assign w_sck_edge = w_sck_rise | w_sck_fall;
  assign w_cs_n     = r_cs_s[1];
  assign w_cs_fall  = r_cs_s[2] & ~r_cs_s[1];
  assign w_mosi     = r_mosi_s[1];
  assign w_active   = ~w_cs_n & ~r_abort;

  // bit_cnt is only ever non-zero in a live frame, so F1 fires once per partial frame
  assign w_f1    = w_cs_n & (r_bit_cnt != '0);
  assign w_f2    = w_active & r_armed & w_sck_edge & (r_ph_cnt < PH_MIN);
  assign w_f3    = ~r_abort & w_cs_fall & w_sck_rise;
  assign w_fault = w_f1 | w_f2 | w_f3;

  assign w_rx_take   = w_active & w_sck_rise & ~w_fault;
  assign w_frame_end = w_rx_take & (r_bit_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abort         <= 1'b1;
      r_armed         <= 1'b0;
      r_bit_cnt       <= '0;
      r_ph_cnt        <= '0;
      r_rx_shift      <= '0;
      o_rx_data       <= '0;
      o_rx_data_ready <= 1'b0;
      o_spi_clk_error <= 1'b0;
      o_spi_miso_oe   <= 1'b0;
    end else begin
      o_spi_clk_error <= w_fault;
      o_rx_data_ready <= w_frame_end;
      o_spi_miso_oe   <= ~w_cs_n;

      // sync_ok keeps the reset value of the cs_n synchroniser from releasing abort
      if (w_fault)
        r_abort <= 1'b1;
      else if (w_cs_n && r_sync_ok[1])
        r_abort <= 1'b0;

      if (w_fault || !w_active)
        r_armed <= 1'b0;
      else if (w_sck_rise)
        r_armed <= 1'b1;

      if (w_sck_edge)
        r_ph_cnt <= '0;
      else if (r_ph_cnt != '1)
        r_ph_cnt <= r_ph_cnt + 1'b1;

      if (w_fault || w_cs_n)
        r_bit_cnt <= '0;
      else if (w_rx_take)
        r_bit_cnt <= w_frame_end ? '0 : r_bit_cnt + 1'b1;

      if (w_rx_take)
        r_rx_shift <= {r_rx_shift[FRAME_BITS-2:0], w_mosi};

      if (w_frame_end)
        o_rx_data <= {r_rx_shift[FRAME_BITS-2:0], w_mosi};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_hold  <= '0;
      r_tx_shift <= '0;
      o_spi_miso <= 1'b0;
    end else begin
      if (i_tx_data_ready)
        r_tx_hold <= i_tx_data;
      else if (w_frame_end)
        r_tx_hold <= '0;

      // between frames the shifter follows tx_hold so bit 15 is on MISO before the first rise
      if (w_cs_n) begin
        r_tx_shift <= r_tx_hold;
        o_spi_miso <= 1'b0;
      end else if (r_bit_cnt == '0) begin
        r_tx_shift <= r_tx_hold;
        o_spi_miso <= r_tx_hold[FRAME_BITS-1];
      end else if (w_sck_fall && w_active) begin
        r_tx_shift <= {r_tx_shift[FRAME_BITS-2:0], 1'b0};
        o_spi_miso <= r_tx_shift[FRAME_BITS-2];
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_phy.sv
// Bench for spi_slave_phy: bit-banged mode-0 master at SCK=clk/8, rx scoreboard, MISO and fault-pulse checks.
module tb_spi_slave_phy;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        tx_rdy = 1'b0;
  logic [15:0] tx_dat = 16'h0;
  logic        miso, miso_oe, rx_rdy, clk_err;
  logic [15:0] rx_dat;

  int          n_checks = 0;
  int          n_pass = 0;
  int          err_cnt = 0;
  int          cyc = 0;
  int          strobe_cyc = -1;
  logic [15:0] sb[$];
  logic [15:0] exp_w;

  spi_slave_phy dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_spi_cs_n      (cs_n),
    .i_spi_sck       (sck),
    .i_spi_mosi      (mosi),
    .o_spi_miso      (miso),
    .o_spi_miso_oe   (miso_oe),
    .o_rx_data_ready (rx_rdy),
    .o_rx_data       (rx_dat),
    .i_tx_data_ready (tx_rdy),
    .i_tx_data       (tx_dat),
    .o_spi_clk_error (clk_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // strobes are matched against the scoreboard as they appear
  always @(negedge clk) begin
    if (rst_n) begin
      if (clk_err) err_cnt++;
      if (rx_rdy) begin
        strobe_cyc = cyc;
        if (sb.size() == 0) begin
          check_val("rx_unexpected_strobe", 32'(rx_rdy), 32'd0);
        end else begin
          exp_w = sb.pop_front();
          check_val("rx_data", 32'(rx_dat), 32'(exp_w));
        end
      end
    end
  end

  // 4 clk low, 4 clk high per bit; MISO sampled as SCK rises
  task automatic send_bits(input logic [15:0] w, input int nbits, input bit exp_rx,
                           input bit collide, input logic [15:0] cw, output logic [15:0] mw);
    int rise_c;
    mw = 16'h0;
    rise_c = 0;
    if (exp_rx) sb.push_back(w);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sck  = 1'b0;
      mosi = w[15-i];
      wait_clk(3);
      @(negedge clk);
      mw     = {mw[14:0], miso};
      sck    = 1'b1;
      rise_c = cyc;
      if (collide && i == nbits - 1) begin
        wait_clk(2);
        tx_rdy = 1'b1;
        tx_dat = cw;
        @(negedge clk);
        tx_rdy = 1'b0;
      end else begin
        wait_clk(3);
      end
    end
    @(negedge clk);
    sck = 1'b0;
    if (exp_rx) check_val("rx_latency", 32'(strobe_cyc - rise_c), 32'd3);
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_val({pfx, "_rx_rdy"}, 32'(rx_rdy), 32'd0);
    check_val({pfx, "_rx_dat"}, 32'(rx_dat), 32'd0);
    check_val({pfx, "_clk_err"}, 32'(clk_err), 32'd0);
    check_val({pfx, "_miso"}, 32'(miso), 32'd0);
    check_val({pfx, "_miso_oe"}, 32'(miso_oe), 32'd0);
  endtask

  initial begin
    logic [15:0] m;
    int e0;

    wait_clk(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    wait_clk(4);

    cs_n = 1'b0;
    wait_clk(4);
    check_val("miso_oe_low_cs", 32'(miso_oe), 32'd1);
    send_bits(16'h0003, 16, 1, 0, 16'h0, m);
    wait_clk(8);
    send_bits(16'hABCD, 16, 1, 0, 16'h0, m);
    check_val("miso_idle_word", 32'(m), 32'h0);
    wait_clk(8);
    check_val("basic_sb_drained", 32'(sb.size()), 32'd0);
    check_val("basic_no_err", 32'(err_cnt), 32'd0);

    send_bits(16'hC001, 16, 1, 0, 16'h0, m);
    wait_clk(2);
    tx_rdy = 1'b1;
    tx_dat = 16'h000A;
    @(negedge clk);
    tx_rdy = 1'b0;
    wait_clk(12);
    send_bits(16'h0000, 16, 1, 0, 16'h0, m);
    check_val("miso_read_word", 32'(m), 32'h000A);
    wait_clk(12);
    send_bits(16'h5555, 16, 1, 0, 16'h0, m);
    check_val("miso_sent_once", 32'(m), 32'h0);
    cs_n = 1'b1;
    wait_clk(8);
    check_val("miso_oe_cs_high", 32'(miso_oe), 32'd0);
    check_val("read_no_err", 32'(err_cnt), 32'd0);

    e0 = err_cnt;
    cs_n = 1'b0;
    wait_clk(4);
    send_bits(16'hFFFF, 9, 0, 0, 16'h0, m);
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
    check_val("partial_err_pulse", 32'(err_cnt - e0), 32'd1);
    cs_n = 1'b0;
    wait_clk(4);
    send_bits(16'h1234, 16, 1, 0, 16'h0, m);
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
    check_val("partial_recover_err", 32'(err_cnt - e0), 32'd1);

    e0 = err_cnt;
    cs_n = 1'b0;
    wait_clk(4);
    send_bits(16'hF0F0, 5, 0, 0, 16'h0, m);
    wait_clk(3);
    @(negedge clk);
    sck = 1'b1;
    @(negedge clk);
    sck = 1'b0;
    wait_clk(4);
    send_bits(16'hFFFF, 6, 0, 0, 16'h0, m);
    wait_clk(4);
    check_val("glitch_err_pulse", 32'(err_cnt - e0), 32'd1);
    cs_n = 1'b1;
    wait_clk(8);
    cs_n = 1'b0;
    wait_clk(4);
    send_bits(16'h8421, 16, 1, 0, 16'h0, m);
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
    check_val("glitch_recover_err", 32'(err_cnt - e0), 32'd1);
    check_val("glitch_sb_drained", 32'(sb.size()), 32'd0);

    e0 = err_cnt;
    cs_n = 1'b0;
    wait_clk(4);
    send_bits(16'hFFFF, 5, 0, 0, 16'h0, m);
    wait_clk(2);
    rst_n = 1'b0;
    wait_clk(2);
    check_outputs_zero("midrst");
    rst_n = 1'b1;
    send_bits(16'hFFFF, 11, 0, 0, 16'h0, m);
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
    check_val("midrst_no_err", 32'(err_cnt - e0), 32'd0);
    cs_n = 1'b0;
    wait_clk(4);
    send_bits(16'h5A5A, 16, 1, 0, 16'h0, m);
    wait_clk(12);

    send_bits(16'h0F0F, 16, 1, 1, 16'hBEEF, m);
    check_val("miso_collide_frame", 32'(m), 32'h0);
    wait_clk(12);
    send_bits(16'h00FF, 16, 1, 0, 16'h0, m);
    check_val("miso_collide_next", 32'(m), 32'hBEEF);
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);

    check_val("final_sb_drained", 32'(sb.size()), 32'd0);
    check_val("final_err_total", 32'(err_cnt), 32'd2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
